mul_div_unit: RTL and testbench
===============================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-high.
REQ-002 Parameter XLEN, default 32, SHALL set the operand and result width; only 32 is required to work.
REQ-003 Port clk  input  1  rising-edge clock.
REQ-004 Port rst  input  1  asynchronous active-high reset.
REQ-005 Port start  input  1  request; sampled only in IDLE.
REQ-006 Port op  input  3  operation; encoding equals the RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 Port A  input  32  first operand (rs1).
REQ-008 Port B  input  32  second operand (rs2).
REQ-009 Port busy  output  1  high while an operation is iterating.
REQ-010 Port done  output  1  one-cycle pulse; Result is valid.
REQ-011 Port Result  output  32  result, fed to the writeback mux alongside the ALU result.
REQ-012 Port Zero  output  1  (Result == 0), combinational.

Function
REQ-013 The state machine SHALL have three states with these transitions: IDLE -start-> BUSY; BUSY -32 iterations-> DONE; DONE -> IDLE (unconditional, one cycle).
REQ-014 On an accepted start, A, B and op SHALL be latched at that clock edge, and input changes after that edge SHALL have no effect on the operation.
REQ-015 Timing for an accepted start at edge k: busy SHALL be 1 for cycles k+1..k+32; done SHALL be 1 in cycle k+33 only; busy and done SHALL never both be 1.
REQ-016 start SHALL be ignored in BUSY and in DONE, and back-to-back operations SHALL therefore be spaced at least 34 cycles apart.
REQ-017 Multiply SHALL be a radix-2 shift-add over 32 iterations producing a 64-bit product.
  - MUL returns the low 32 bits; MULH, MULHSU and MULHU return the high 32 bits.
  - Operand signedness: MULH signed×signed, MULHSU signed A × unsigned B, MULHU unsigned×unsigned.
REQ-018 Divide SHALL be a radix-2 restoring division over 32 iterations on operand magnitudes, with signs fixed up afterwards.
  - The quotient truncates toward zero.
  - The remainder takes the sign of A.
REQ-019 Divide by zero (B = 0) SHALL return quotient 0xFFFFFFFF (DIV, DIVU) and remainder A (REM, REMU), with the normal 33-cycle latency.
REQ-020 Signed overflow (A = 0x80000000, B = 0xFFFFFFFF) SHALL return DIV 0x80000000 and REM 0, with the normal latency.
REQ-021 Result SHALL update only in the DONE cycle and SHALL hold its value until the next DONE.
REQ-022 Result SHALL never show intermediate iteration values.

Reset
REQ-023 While rst = 1, the block SHALL enter IDLE, clear the iteration counter, and drive busy = 0, done = 0, Result = 0 (hence Zero = 1).
REQ-024 A reset asserted mid-operation SHALL abort the operation, with no done pulse afterwards.
REQ-025 A start sampled in the first clock edge after rst deasserts SHALL be accepted normally.

Structure
REQ-026 Package mdu_pkg SHALL hold the op encoding constants (funct3 values), the state enum (IDLE, BUSY, DONE) and ITER = 32.
REQ-027 Sign handling (operand absolute value and result negation) SHALL be a single combinational sub-module, mdu_sign_adjust.
REQ-028 The iteration datapath SHALL be shared between multiply and divide, using one 64-bit accumulator and a 6-bit counter.

Verification
REQ-029 MUL, A = 7, B = 0xFFFFFFFD, start at edge 0 -> busy for cycles 1..32, done in cycle 33, Result 0xFFFFFFEB, Zero = 0.
REQ-030 High-half multiplies -> results:
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 Signed divide with A = 0xFFFFFFF9 (−7), B = 2 -> DIV 0xFFFFFFFD, REM 0xFFFFFFFF.
  - Same A, B with DIVU -> 0x7FFFFFFC; with REMU -> 1.
REQ-032 Corner cases -> results:
  - DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0, Zero = 1.
REQ-033 Start DIVU 100/7; at cycle 5 change A to 0 and pulse start -> done only in cycle 33, Result 14; the second start is not queued.
REQ-034 Start MUL 3×4; assert rst at cycle 10 -> busy = 0 and Result = 0 immediately, no done within the next 40 cycles.
  - A subsequent MUL 3×4 then yields 12 in done cycle 33.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit: RV32M funct3
// encodings, controller state encoding and the iteration count.
package mdu_pkg;

  localparam int ITER = 32;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

endpackage

// File: rtl/mdu_sign_adjust.sv
// Combinational sign handling: operand magnitudes on the way in, and
// sign restoration of the unsigned iteration result on the way out.
module mdu_sign_adjust
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        op_in,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   a_mag,
  output logic [XLEN-1:0]   b_mag,
  output logic              a_neg,
  output logic              b_neg,
  input  logic [2:0]        res_op,
  input  logic [2*XLEN-1:0] raw,
  input  logic              raw_a_neg,
  input  logic              raw_b_neg,
  input  logic              raw_b_zero,
  output logic [XLEN-1:0]   res
);

  logic              a_signed;
  logic              b_signed;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quot;
  logic [XLEN-1:0]   rem;

  // Operand magnitudes; unsigned operands pass through untouched
  always_comb begin
    a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
               (op_in == OP_DIV)  || (op_in == OP_REM);
    b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? (~a + 1'b1) : a;
    b_mag    = b_neg ? (~b + 1'b1) : b;
  end

  // Result sign fix-up; a zero divisor keeps the all-ones quotient unsigned
  always_comb begin
    prod = (raw_a_neg ^ raw_b_neg) ? (~raw + 1'b1) : raw;
    quot = raw[XLEN-1:0];
    rem  = raw[2*XLEN-1:XLEN];
    res  = '0;
    case (res_op)
      OP_MUL:                       res = prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              res = ((raw_a_neg ^ raw_b_neg) && !raw_b_zero) ?
                                          (~quot + 1'b1) : quot;
      default:                      res = raw_a_neg ? (~rem + 1'b1) : rem;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and
// restoring divide sharing one 64-bit accumulator.
//
// state | meaning
// IDLE  | waiting for start; operands latched when start is seen
// BUSY  | one shift-add / restoring-subtract step per cycle, 32 steps
// DONE  | Result valid, done pulses for this single cycle
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] Result,
  output logic            Zero
);

  state_t            state;
  logic [5:0]        cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] next_acc;
  logic [XLEN-1:0]   opnd;
  logic [2:0]        op_q;
  logic              a_neg_q;
  logic              b_neg_q;
  logic              b_zero_q;

  logic [XLEN-1:0]   a_mag;
  logic [XLEN-1:0]   b_mag;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   res;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_hi;
  logic [XLEN:0]     div_diff;

  mdu_sign_adjust #(.XLEN(XLEN)) u_sign (
    .op_in      (op),
    .a          (A),
    .b          (B),
    .a_mag      (a_mag),
    .b_mag      (b_mag),
    .a_neg      (a_neg),
    .b_neg      (b_neg),
    .res_op     (op_q),
    .raw        (next_acc),
    .raw_a_neg  (a_neg_q),
    .raw_b_neg  (b_neg_q),
    .raw_b_zero (b_zero_q),
    .res        (res)
  );

  // One iteration step: multiply adds into the high half and shifts right,
  // divide shifts left and keeps the trial subtraction when it does not borrow
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} +
               (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    div_hi   = acc[2*XLEN-1:XLEN-1];
    div_diff = div_hi - {1'b0, opnd};
    if (is_div(op_q)) begin
      if (div_diff[XLEN])
        next_acc = {div_hi[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      else
        next_acc = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      next_acc = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Controller; Result is loaded from the final step so it appears with done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_q     <= '0;
      a_neg_q  <= 1'b0;
      b_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q     <= op;
            a_neg_q  <= a_neg;
            b_neg_q  <= b_neg;
            b_zero_q <= (B == '0);
            acc      <= is_div(op) ? {{XLEN{1'b0}}, a_mag} : {{XLEN{1'b0}}, b_mag};
            opnd     <= is_div(op) ? b_mag : a_mag;
            cnt      <= 6'(ITER - 1);
            busy     <= 1'b1;
            state    <= BUSY;
          end
        end
        BUSY: begin
          acc <= next_acc;
          if (cnt == '0) begin
            Result <= res;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign Zero = (Result == '0);

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: arithmetic reference model plus
// per-cycle comparison, and directed vectors with hand-computed results.
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy;
  logic        done;
  logic [31:0] Result;
  logic        Zero;

  int n_checks = 0;
  int n_fail   = 0;

  mul_div_unit #(.XLEN(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .done   (done),
    .Result (Result),
    .Zero   (Zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, p;
    logic [63:0] pu;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    case (f)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ua; return p[63:32]; end
      OP_MULHU:  begin pu = {32'h0, a} * {32'h0, b}; return pu[63:32]; end
      OP_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      OP_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Timing/result model: k is the accepting edge, outputs follow from e-k
  int          e = 0;
  int          k = -1000;
  int          d;
  logic [31:0] pend = '0;
  logic [31:0] m_res = '0;
  logic        exp_busy = 1'b0;
  logic        exp_done = 1'b0;

  always @(posedge clk) begin
    e++;
    if (rst) begin
      k     = -1000;
      m_res = '0;
    end else begin
      if ((e - k) >= 34 && start) begin
        k    = e;
        pend = model(op, A, B);
      end
      if ((e - k) == 32) m_res = pend;
    end
    d        = e - k;
    exp_busy = !rst && d >= 0 && d <= 31;
    exp_done = !rst && d == 32;
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (e > 0) begin
      chk("busy", {31'b0, busy}, {31'b0, exp_busy});
      chk("done", {31'b0, done}, {31'b0, exp_done});
      chk("result", Result, m_res);
      chk("zero", {31'b0, Zero}, {31'b0, (m_res == 0)});
      chk("busy_and_done", {31'b0, busy & done}, 32'h0);
    end
  end

  // Called just after a falling edge; returns at the falling edge of the done cycle
  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, output logic [31:0] r);
    int lat;
    op = f; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
      if (lat == 1 || lat == 32) chk({name, "_busy_edge"}, {31'b0, busy}, 32'h1);
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL %s_timeout: no done within %0d cycles, required by 33", name, lat);
    end
    chk({name, "_latency"}, lat, 33);
    r = Result;
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] x;
  } vec_t;

  vec_t        vecs [14];
  logic [31:0] r;
  int          lat;
  int          n_done;

  initial begin
    vecs[0]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[1]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[3]  = '{OP_DIV,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD};
    vecs[4]  = '{OP_REM,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF};
    vecs[5]  = '{OP_DIVU,   32'hFFFF_FFF9, 32'h2,         32'h7FFF_FFFC};
    vecs[6]  = '{OP_REMU,   32'hFFFF_FFF9, 32'h2,         32'h1};
    vecs[7]  = '{OP_DIVU,   32'h5,         32'h0,         32'hFFFF_FFFF};
    vecs[8]  = '{OP_REMU,   32'h5,         32'h0,         32'h5};
    vecs[9]  = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[10] = '{OP_DIV,    32'hFFFF_FF9C, 32'h7,         32'hFFFF_FFF2};
    vecs[11] = '{OP_REM,    32'h64,        32'hFFFF_FFF9, 32'h2};
    vecs[12] = '{OP_DIV,    32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFFF};
    vecs[13] = '{OP_MULHU,  32'h0001_0000, 32'h0001_0000, 32'h1};

    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_done", {31'b0, done}, 32'h0);
    chk("reset_result", Result, 32'h0);
    chk("reset_zero", {31'b0, Zero}, 32'h1);

    // Start accepted on the first edge after reset release
    @(negedge clk); #1 rst = 1'b0;
    run_op("mul_7x-3", OP_MUL, 32'h7, 32'hFFFF_FFFD, r);
    chk("mul_7x-3", r, 32'hFFFF_FFEB);
    chk("mul_7x-3_zero", {31'b0, Zero}, 32'h0);

    for (int i = 0; i < 14; i++) begin
      chk($sformatf("model_vec%0d", i), model(vecs[i].f, vecs[i].a, vecs[i].b), vecs[i].x);
      @(negedge clk); #1;
      run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, r);
      chk($sformatf("vec%0d", i), r, vecs[i].x);
    end

    @(negedge clk); #1;
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, r);
    chk("rem_ovf", r, 32'h0);
    chk("rem_ovf_zero", {31'b0, Zero}, 32'h1);

    // Inputs changing and start pulsing mid-operation have no effect
    @(negedge clk); #1;
    op = OP_DIVU; A = 32'd100; B = 32'd7; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0;
    repeat (4) begin @(negedge clk); lat++; end
    #1 A = 32'h0; start = 1'b1;
    @(negedge clk); lat++;
    #1 start = 1'b0;
    while (!done && lat < 60) begin @(negedge clk); lat++; end
    chk("divu_ignore_latency", lat, 33);
    chk("divu_ignore_result", Result, 32'd14);
    n_done = 0;
    repeat (40) begin @(negedge clk); if (done) n_done++; end
    chk("divu_not_queued", n_done, 0);

    // Reset mid-operation aborts with no done afterwards
    @(negedge clk); #1;
    op = OP_MUL; A = 32'd3; B = 32'd4; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {31'b0, busy}, 32'h0);
    chk("abort_result", Result, 32'h0);
    chk("abort_zero", {31'b0, Zero}, 32'h1);
    @(negedge clk); #1 rst = 1'b0;
    n_done = 0;
    repeat (40) begin @(negedge clk); if (done) n_done++; end
    chk("abort_no_done", n_done, 0);

    @(negedge clk); #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    run_op("mul_3x4", OP_MUL, 32'd3, 32'd4, r);
    chk("mul_3x4", r, 32'd12);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
